// File: rtl/keyboard_matrix.sv
// keyboard_matrix: PS/2 set-2 key events -> ZX Spectrum 8x5 matrix.
// Direct keys are held in phys_r. Multi-key chords for PC-only keys go in a
// separate virt register. The read path ORs the selected rows and is
// registered.
// Optional build macro: KBD_CHORD_EN enables the chord keys (virt register).
// Without it, virt is zero, chord codes are unmapped and every ext=1 code is
// ignored.
// Matrix bit index = row * 5 + column.
module keyboard_matrix (
    input  logic       clock,
    input  logic       reset,
    input  logic       kstb,
    input  logic       pressed,
    input  logic       ext,
    input  logic [7:0] code,
    input  logic [7:0] row,
    output logic [4:0] col,
    output logic       anykey
);

    // Direct lookup: returns {hit, bit index} for a non-extended set-2 code.
    function automatic logic [6:0] direct_lookup(input logic [7:0] c);
        logic [6:0] r;
        case (c)
            8'h12: r = {1'b1, 6'd0};   // CS
            8'h1A: r = {1'b1, 6'd1};   // Z
            8'h22: r = {1'b1, 6'd2};   // X
            8'h21: r = {1'b1, 6'd3};   // C
            8'h2A: r = {1'b1, 6'd4};   // V
            8'h1C: r = {1'b1, 6'd5};   // A
            8'h1B: r = {1'b1, 6'd6};   // S
            8'h23: r = {1'b1, 6'd7};   // D
            8'h2B: r = {1'b1, 6'd8};   // F
            8'h34: r = {1'b1, 6'd9};   // G
            8'h15: r = {1'b1, 6'd10};  // Q
            8'h1D: r = {1'b1, 6'd11};  // W
            8'h24: r = {1'b1, 6'd12};  // E
            8'h2D: r = {1'b1, 6'd13};  // R
            8'h2C: r = {1'b1, 6'd14};  // T
            8'h16: r = {1'b1, 6'd15};  // 1
            8'h1E: r = {1'b1, 6'd16};  // 2
            8'h26: r = {1'b1, 6'd17};  // 3
            8'h25: r = {1'b1, 6'd18};  // 4
            8'h2E: r = {1'b1, 6'd19};  // 5
            8'h45: r = {1'b1, 6'd20};  // 0
            8'h46: r = {1'b1, 6'd21};  // 9
            8'h3E: r = {1'b1, 6'd22};  // 8
            8'h3D: r = {1'b1, 6'd23};  // 7
            8'h36: r = {1'b1, 6'd24};  // 6
            8'h4D: r = {1'b1, 6'd25};  // P
            8'h44: r = {1'b1, 6'd26};  // O
            8'h43: r = {1'b1, 6'd27};  // I
            8'h3C: r = {1'b1, 6'd28};  // U
            8'h35: r = {1'b1, 6'd29};  // Y
            8'h5A: r = {1'b1, 6'd30};  // ENTER
            8'h4B: r = {1'b1, 6'd31};  // L
            8'h42: r = {1'b1, 6'd32};  // K
            8'h3B: r = {1'b1, 6'd33};  // J
            8'h33: r = {1'b1, 6'd34};  // H
            8'h29: r = {1'b1, 6'd35};  // SPACE
            8'h14: r = {1'b1, 6'd36};  // SS (LCtrl)
            8'h3A: r = {1'b1, 6'd37};  // M
            8'h31: r = {1'b1, 6'd38};  // N
            8'h32: r = {1'b1, 6'd39};  // B
            default: r = 7'd0;
        endcase
        return r;
    endfunction

`ifdef KBD_CHORD_EN
    // Chord lookup: returns the two matrix bits a chord key drives.
    function automatic logic [39:0] chord_mask(input logic e, input logic [7:0] c);
        logic [39:0] m;
        m = 40'd0;
        case ({e, c})
            9'h066: begin m[0] = 1'b1; m[20] = 1'b1; end  // Backspace: CS+0
            9'h16B: begin m[0] = 1'b1; m[19] = 1'b1; end  // Left:  CS+5
            9'h172: begin m[0] = 1'b1; m[24] = 1'b1; end  // Down:  CS+6
            9'h175: begin m[0] = 1'b1; m[23] = 1'b1; end  // Up:    CS+7
            9'h174: begin m[0] = 1'b1; m[22] = 1'b1; end  // Right: CS+8
            9'h076: begin m[0] = 1'b1; m[35] = 1'b1; end  // Esc:   CS+SPACE
            default: m = 40'd0;
        endcase
        return m;
    endfunction
`endif

    logic [39:0] phys_r;
    logic [39:0] phys_nxt_s;
    logic [39:0] virt_s;
    logic [39:0] key_s;
    logic        hit_s;
    logic [5:0]  idx_s;
    logic [4:0]  acc_s;
    logic [4:0]  col_nxt_s;
    logic        any_nxt_s;
    logic [4:0]  col_r;
    logic        anykey_r;

`ifdef KBD_CHORD_EN
    logic [39:0] virt_r;
    logic [39:0] virt_nxt_s;
    logic [39:0] cmask_s;

    // Chord state: a chord make sets both its bits, a break clears both.
    always_comb begin
        cmask_s = chord_mask(ext, code);
        if (kstb && (cmask_s != 40'd0)) begin
            if (pressed) begin
                virt_nxt_s = virt_r | cmask_s;
            end else begin
                virt_nxt_s = virt_r & ~cmask_s;
            end
        end else begin
            virt_nxt_s = virt_r;
        end
    end

    // Chord state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            virt_r <= 40'd0;
        end else begin
            virt_r <= virt_nxt_s;
        end
    end

    assign virt_s = virt_r;
`else
    assign virt_s = 40'd0;
`endif

    assign key_s = phys_r | virt_s;

    // Direct state: a mapped non-extended code writes its bit to the make/break value.
    always_comb begin
        {hit_s, idx_s} = direct_lookup(code);
        phys_nxt_s     = phys_r;
        if (kstb && !ext && hit_s) begin
            phys_nxt_s[idx_s] = pressed;
        end else begin
            phys_nxt_s = phys_r;
        end
    end

    // Read path: OR the columns of every row whose select line is low.
    always_comb begin
        acc_s = 5'd0;
        for (int r = 0; r < 8; r++) begin
            if (row[r] == 1'b0) begin
                acc_s = acc_s | key_s[r*5 +: 5];
            end else begin
                acc_s = acc_s;
            end
        end
        col_nxt_s = ~acc_s;
        any_nxt_s = |key_s;
    end

    // Direct key state and registered read outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            phys_r   <= 40'd0;
            col_r    <= 5'h1F;
            anykey_r <= 1'b0;
        end else begin
            phys_r   <= phys_nxt_s;
            col_r    <= col_nxt_s;
            anykey_r <= any_nxt_s;
        end
    end

    assign col    = col_r;
    assign anykey = anykey_r;

endmodule

// File: tb/tb_keyboard_matrix.sv
// tb_keyboard_matrix: directed key events with a scoreboard queue.
// Stimulus pushes expected {col, anykey} tagged with the cycle it is due;
// the monitor pops and compares on the falling edge.
module tb_keyboard_matrix;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       kstb = 1'b0;
    logic       pressed = 1'b0;
    logic       ext = 1'b0;
    logic [7:0] code = 8'h00;
    logic [7:0] row = 8'hFF;
    logic [4:0] col;
    logic       anykey;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic drain = 1'b0;
    logic drain_done = 1'b0;

    int        q_due[$];
    logic [4:0] q_col[$];
    logic      q_any[$];
    string     q_name[$];

    keyboard_matrix dut (
        .clock   (clock),
        .reset   (reset),
        .kstb    (kstb),
        .pressed (pressed),
        .ext     (ext),
        .code    (code),
        .row     (row),
        .col     (col),
        .anykey  (anykey)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: compare every expectation due on this cycle.
    always @(negedge clock) begin
        while (q_due.size() > 0 && q_due[0] <= cyc) begin
            int d;
            logic [4:0] ec;
            logic ea;
            string nm;
            d  = q_due.pop_front();
            ec = q_col.pop_front();
            ea = q_any.pop_front();
            nm = q_name.pop_front();
            total++;
            if (d != cyc || col !== ec || anykey !== ea) begin
                bad++;
                $display("FAIL %s: got col=%h anykey=%b (cycle %0d), need col=%h anykey=%b (cycle %0d)",
                         nm, col, anykey, cyc, ec, ea, d);
            end
        end
        if (drain && !drain_done) begin
            drain_done <= 1'b1;
            total++;
            if (q_due.size() != 0) begin
                bad++;
                $display("FAIL drain: got %0d pending expectations, need 0", q_due.size());
            end
        end
    end

    task automatic key(input logic p, input logic e, input logic [7:0] c);
        @(negedge clock);
        kstb = 1'b1; pressed = p; ext = e; code = c;
        @(negedge clock);
        kstb = 1'b0; pressed = 1'b0; ext = 1'b0; code = 8'h00;
    endtask

    task automatic expect_row(input string nm, input logic [7:0] r,
                              input logic [4:0] ec, input logic ea);
        @(negedge clock);
        row = r;
        q_due.push_back(cyc + 1);
        q_col.push_back(ec);
        q_any.push_back(ea);
        q_name.push_back(nm);
        @(negedge clock);
    endtask

    initial begin
        // Reset, with a make issued while reset is held.
        row = 8'h00;
        repeat (2) @(negedge clock);
        key(1'b1, 1'b0, 8'h1C);
        expect_row("reset_state", 8'h00, 5'h1F, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        expect_row("after_reset", 8'h00, 5'h1F, 1'b0);

        // Single key A at r1c0.
        key(1'b1, 1'b0, 8'h1C);
        expect_row("a_row1", 8'hFD, 5'h1E, 1'b1);
        expect_row("a_row0", 8'hFE, 5'h1F, 1'b1);
        key(1'b0, 1'b0, 8'h1C);
        expect_row("a_break", 8'hFD, 5'h1F, 1'b0);

        // Two rows selected: 1 (r3c0) and Z (r0c1).
        key(1'b1, 1'b0, 8'h16);
        key(1'b1, 1'b0, 8'h1A);
        expect_row("multi_row", 8'hF6, 5'h1C, 1'b1);
        expect_row("z_only", 8'hFE, 5'h1D, 1'b1);
        expect_row("one_only", 8'hF7, 5'h1E, 1'b1);
        key(1'b0, 1'b0, 8'h1A);
        key(1'b1, 1'b0, 8'h16);
        key(1'b1, 1'b0, 8'h16);
        key(1'b0, 1'b0, 8'h16);
        expect_row("typematic_break", 8'hF7, 5'h1F, 1'b0);

        // X, V, B across r0 and r7; FFh selects nothing.
        key(1'b1, 1'b0, 8'h22);
        key(1'b1, 1'b0, 8'h2A);
        key(1'b1, 1'b0, 8'h32);
        expect_row("xvb_r0r7", 8'h7E, 5'h0B, 1'b1);
        expect_row("no_row", 8'hFF, 5'h1F, 1'b1);
        key(1'b0, 1'b0, 8'h22);
        key(1'b0, 1'b0, 8'h2A);
        key(1'b0, 1'b0, 8'h32);
        expect_row("xvb_released", 8'h00, 5'h1F, 1'b0);

        // Unmapped code, stray break, extended code that would map directly.
        key(1'b1, 1'b0, 8'h0E);
        key(1'b0, 1'b0, 8'h1D);
        key(1'b1, 1'b1, 8'h1C);
        key(1'b1, 1'b1, 8'h12);
        expect_row("ignored_codes", 8'h00, 5'h1F, 1'b0);

        // Reset mid-hold, then the late break.
        key(1'b1, 1'b0, 8'h5A);
        expect_row("enter_held", 8'hBF, 5'h1E, 1'b1);
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        expect_row("reset_mid_hold", 8'hBF, 5'h1F, 1'b0);
        key(1'b0, 1'b0, 8'h5A);
        expect_row("late_break", 8'h00, 5'h1F, 1'b0);

        // Reset coincident with a make.
        @(negedge clock);
        reset = 1'b1; kstb = 1'b1; pressed = 1'b1; code = 8'h29;
        @(negedge clock);
        reset = 1'b0; kstb = 1'b0; pressed = 1'b0; code = 8'h00;
        expect_row("reset_wins", 8'h7F, 5'h1F, 1'b0);

`ifdef KBD_CHORD_EN
        // Left arrow = CS+5; LShift keeps CS after the arrow is released.
        key(1'b1, 1'b1, 8'h6B);
        expect_row("left_cs", 8'hFE, 5'h1E, 1'b1);
        expect_row("left_5", 8'hF7, 5'h0F, 1'b1);
        key(1'b1, 1'b0, 8'h12);
        key(1'b0, 1'b1, 8'h6B);
        expect_row("lshift_keeps_cs", 8'hFE, 5'h1E, 1'b1);
        expect_row("left_5_cleared", 8'hF7, 5'h1F, 1'b1);
        key(1'b0, 1'b0, 8'h12);
        expect_row("cs_released", 8'h00, 5'h1F, 1'b0);

        // Backspace break leaves a directly held 0.
        key(1'b1, 1'b0, 8'h66);
        key(1'b1, 1'b0, 8'h45);
        key(1'b0, 1'b0, 8'h66);
        expect_row("zero_kept", 8'hEF, 5'h1E, 1'b1);
        expect_row("bksp_cs_gone", 8'hFE, 5'h1F, 1'b1);
        key(1'b0, 1'b0, 8'h45);

        // Other chords.
        key(1'b1, 1'b1, 8'h75);
        expect_row("up_7", 8'hEF, 5'h17, 1'b1);
        key(1'b0, 1'b1, 8'h75);
        key(1'b1, 1'b1, 8'h72);
        expect_row("down_6", 8'hEF, 5'h0F, 1'b1);
        key(1'b0, 1'b1, 8'h72);
        key(1'b1, 1'b1, 8'h74);
        expect_row("right_8", 8'hEE, 5'h1A, 1'b1);
        key(1'b0, 1'b1, 8'h74);
        key(1'b1, 1'b0, 8'h76);
        expect_row("esc_cs_spc", 8'h7E, 5'h1E, 1'b1);
        key(1'b0, 1'b0, 8'h76);
        expect_row("chords_released", 8'h00, 5'h1F, 1'b0);
`else
        // Chord codes are unmapped in this build.
        key(1'b1, 1'b0, 8'h66);
        expect_row("bksp_ignored", 8'h00, 5'h1F, 1'b0);
        key(1'b1, 1'b1, 8'h6B);
        key(1'b1, 1'b0, 8'h76);
        expect_row("chords_ignored", 8'h00, 5'h1F, 1'b0);
`endif

        repeat (3) @(negedge clock);
        drain = 1'b1;
        repeat (2) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, need completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/keyboard_matrix.md
Name: keyboard_matrix

Overview:
- Converts the user_io key stream (key_strobe/key_code/key_pressed/key_extended, PS/2 set-2 codes) into the ZX Spectrum 8x5 keyboard matrix.
- main reads the matrix on port 0xFE reads, using the high address byte as the row select.
- Sits between user_io and main.
- Also synthesises multi-key chords for PC keys with no single ZX equivalent.

Parameters:
- none

Ports:
- clock    in   1  system clock (56.7 MHz)
- reset    in   1  synchronous, active-high; clears all key state
- kstb     in   1  one-cycle key event strobe
- pressed  in   1  1 = make, 0 = break; valid with kstb
- ext      in   1  1 = E0-prefixed code; valid with kstb
- code     in   8  set-2 scan code; valid with kstb
- row      in   8  CPU A15..A8; active-low row select
- col      out  5  matrix column read D4..D0; active-low
- anykey   out  1  1 while any matrix bit (physical or virtual) is set

Behaviour:
- State held as two 40-bit registers:
  - phys[r][c] for direct keys.
  - virt[r][c] for chord contributions.
  - Effective key[r][c] = phys | virt.
- Row layout, bits c0..c4:
  - r0 CS Z X C V
  - r1 A S D F G
  - r2 Q W E R T
  - r3 1 2 3 4 5
  - r4 0 9 8 7 6
  - r5 P O I U Y
  - r6 ENT L K J H
  - r7 SPC SS M N B
- Direct map (ext=0), standard set-2 positions. Fixed anchors:
  - 12h (LShift) -> r0c0 CS
  - 14h (LCtrl) -> r7c1 SS
  - 29h -> r7c0
  - 5Ah -> r6c0
  - 1Ch -> r1c0
  - 16h -> r3c0
  - 45h -> r4c0
  - 1Ah -> r0c1
- Event handling, on the clock edge where kstb=1:
  - A mapped code sets (pressed=1) or clears (pressed=0) its bit.
  - Unmapped codes are ignored.
  - Updates take effect from the next cycle.
- Repeated make of a held key (typematic) is idempotent.
- A break for a key not held is a no-op.
- Direct and chord states are independent:
  - Releasing Backspace does not clear CS while LShift is held.
  - Releasing LShift does not clear CS while an arrow key is held.
- Read path: registered.
  - col[c] = ~( OR over r with row[r]=0 of key[r][c] ).
  - Output updates on the clock edge after row or state changes (1-cycle latency).
  - row=FFh gives col=1Fh.
  - Multiple low row bits OR their columns.
- anykey is registered, with the same 1-cycle latency as col.
- Reset:
  - Clears phys and virt.
  - Forces col=1Fh and anykey=0 on the next edge.
  - Reset wins over a coincident kstb.
  - A reset mid-hold means the later break is a harmless no-op.
- No ghosting model: arbitrary key combinations read back exactly.

Optional Feature:
- Macro: KBD_CHORD_EN.
- Defined: virt is populated by chord keys. Each chord key sets both of its bits in virt on make and clears both on break:
  - 66h Backspace -> CS+0
  - ext 6Bh Left -> CS+5
  - ext 72h Down -> CS+6
  - ext 75h Up -> CS+7
  - ext 74h Right -> CS+8
  - 76h Esc -> CS+SPC
- Undefined:
  - virt is absent (tied to 0).
  - Chord codes are treated as unmapped.
  - All ext=1 codes are ignored.

Test Plan:
- Reset then row=00h -> col=1Fh, anykey=0; any kstb issued during reset leaves col=1Fh after reset deasserts.
- kstb code=1Ch pressed=1; row=FDh -> col=1Eh one cycle later; row=FEh -> col=1Fh; break 1Ch -> col=1Fh on row=FDh.
- Press 16h and 1Ah, row=F6h (r0+r3) -> col=1Ch; make 16h sent three times then one break -> bit cleared.
- KBD_CHORD_EN: make ext 6Bh -> row=FEh gives col=1Eh, row=F7h gives col=0Fh. Make 12h, break ext 6Bh -> row=FEh still 1Eh, row=F7h gives 1Fh.
- KBD_CHORD_EN: make 66h and 45h, break 66h -> row=EFh col=1Eh (0 still held), row=FEh col=1Fh.
- Without KBD_CHORD_EN: make 66h -> col=1Fh for all rows, anykey=0.
